// File: rtl/div32_seq.sv
// Sequential restoring divider: one quotient bit per clock, signed or unsigned operands.
// A start in IDLE or DONE launches an operation; results are registered when it completes.
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [5:0]       cnt;
    logic [WIDTH:0]   part_rem;
    logic [WIDTH-1:0] quo_sh;
    logic [WIDTH-1:0] dvsr_mag;
    logic             neg_q;
    logic             neg_r;

    logic             accept;
    logic             by_zero;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;

    // Two's-complement negation; the most negative value wraps onto itself.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic sgn);
        return (sgn && v[WIDTH-1]) ? negate(v) : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic neg);
        return neg ? negate(v) : v;
    endfunction

    assign accept  = start && (state == IDLE || state == DONE);
    assign by_zero = (divisor == '0);
    assign busy    = (state == RUN) || (state == FIX);
    assign done    = (state == DONE);

    // Restoring step: the subtract result's top bit is the borrow, because the
    // partial remainder is always below the divisor before the shift.
    assign shifted = (part_rem << 1) | {{WIDTH{1'b0}}, quo_sh[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvsr_mag};
    assign borrow  = trial[WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = by_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == 6'(WIDTH - 1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (accept) begin
                    state_nxt = by_zero ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt         <= '0;
            div_by_zero <= by_zero;
            if (by_zero) begin
                quotient  <= '1;
                remainder <= dividend;
            end
        end else begin
            case (state)
                RUN: begin
                    cnt <= cnt + 6'd1;
                end
                FIX: begin
                    quotient  <= apply_sign(quo_sh, neg_q);
                    remainder <= apply_sign(part_rem[WIDTH-1:0], neg_r);
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath: operands captured as magnitudes; quo_sh shifts dividend bits out
    // at the top while quotient bits enter at the bottom.
    always_ff @(posedge clk) begin
        if (accept) begin
            part_rem <= '0;
            quo_sh   <= magnitude(dividend, is_signed);
            dvsr_mag <= magnitude(divisor, is_signed);
            neg_q    <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r    <= is_signed && dividend[WIDTH-1];
        end else if (state == RUN) begin
            part_rem <= borrow ? shifted : trial;
            quo_sh   <= {quo_sh[WIDTH-2:0], ~borrow};
        end
    end

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_div32_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div32_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit truncating division, result reduced modulo 2^32.
    function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic z);
        longint sa;
        longint sb;
        longint lq;
        longint lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else begin
            sa = s ? longint'($signed(a)) : longint'({32'd0, a});
            sb = s ? longint'($signed(b)) : longint'({32'd0, b});
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
            z  = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents an operation for one edge (E0), then scrambles the inputs.
    task automatic launch(input bit s, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        tick();
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input bit s, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        int          n;
        ref_div(s, a, b, eq, er, ez);
        launch(s, a, b);
        if (!ez) begin
            check({tag, " busy_after_start"}, 32'(busy), 32'd1);
            check({tag, " done_early"}, 32'(done), 32'd0);
        end
        wait_done(n);
        check({tag, " latency"}, 32'(n), ez ? 32'd0 : 32'd33);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int          n;
        logic        seen;
        logic [31:0] a;
        logic [31:0] b;
        bit          s;

        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        tick();
        start = 1'b1;
        divisor = 32'd3;
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset flag", 32'(div_by_zero), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();

        run_op("u100_7", 1'b0, 32'd100, 32'd7);
        check("u100_7 quotient_const", quotient, 32'd14);
        tick();
        check("done_single_pulse", 32'(done), 32'd0);

        run_op("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        check("s-7_2 quotient_const", quotient, 32'hFFFF_FFFD);
        run_op("uffff_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        tick();

        run_op("u5_0", 1'b0, 32'd5, 32'd0);
        check("u5_0 remainder_const", remainder, 32'd5);
        // Started in the DONE cycle of the divide-by-zero.
        run_op("u9_3", 1'b0, 32'd9, 32'd3);
        tick();

        run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check("s_ovf quotient_const", quotient, 32'h8000_0000);
        repeat (3) tick();
        check("hold quotient", quotient, 32'h8000_0000);
        check("hold done", 32'(done), 32'd0);
        run_op("s-9_0", 1'b1, 32'hFFFF_FFF7, 32'd0);
        tick();

        launch(1'b0, 32'd20, 32'd3);
        repeat (4) tick();
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd99;
        divisor   = 32'd9;
        tick();
        start = 1'b0;
        wait_done(n);
        check("ignore latency", 32'(n), 32'd28);
        check("ignore quotient", quotient, 32'd6);
        check("ignore remainder", remainder, 32'd2);
        tick();

        launch(1'b0, 32'd50, 32'd5);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort quotient", quotient, 32'd0);
        check("abort remainder", remainder, 32'd0);
        check("abort flag", 32'(div_by_zero), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            seen |= done;
        end
        check("abort no_done", 32'(seen), 32'd0);
        run_op("u50_5", 1'b0, 32'd50, 32'd5);
        tick();

        for (int i = 0; i < 150; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = 32'd1;
                2: b = 32'hFFFF_FFFF;
                3: a = 32'h8000_0000;
                4: b = 32'($urandom_range(1, 20));
                5: b = b >> $urandom_range(1, 31);
                default: begin
                end
            endcase
            run_op($sformatf("rand%0d", i), s, a, b);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
